// File: rtl/lz77_pkg.sv
// Shared LZ77 constants and FSM state encoding (encoder and decoder).
package lz77_pkg;
   localparam int          WSEARCH = 9;
   localparam int          WCHAR   = 8;
   localparam int          WOFF    = 4;
   localparam int          WLEN    = 3;
   localparam logic [7:0]  END_SGN = 8'h24;

   typedef enum logic [1:0] {IDLE, COPY, LIT, DONE} state_t;
endpackage

// File: rtl/lz77_search_buf.sv
// Sliding search buffer: sb[0] holds the newest char, oldest drops off the end.
module lz77_search_buf
   import lz77_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             shift_en,
   input  logic [WCHAR-1:0] din,
   input  logic [WOFF-1:0]  rd_idx,
   output logic [WCHAR-1:0] rd_data
);
   logic [WCHAR-1:0] sb [WSEARCH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < WSEARCH; i++) sb[i] <= '0;
      end else if (shift_en) begin
         sb[0] <= din;
         for (int i = 1; i < WSEARCH; i++) sb[i] <= sb[i-1];
      end
   end

   // Indices beyond the window read as zero rather than wrapping.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < WSEARCH; i++)
         if (rd_idx == WOFF'(i)) rd_data = sb[i];
   end
endmodule

// File: rtl/lz77_decoder_stream.sv
// LZ77 token decoder: expands (offset, match_len, char) tokens into one byte per cycle.
module lz77_decoder_stream
   import lz77_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WOFF-1:0]  offset,
   input  logic [WLEN-1:0]  match_len,
   input  logic [WCHAR-1:0] chardata,
   output logic             out_valid,
   output logic [WCHAR-1:0] char_nxt,
   output logic             encode,
   output logic             finish,
   output logic             err_offset
);
   state_t           state, state_nxt;
   logic [WOFF-1:0]  off_q;
   logic [WLEN-1:0]  len_q, cnt;
   logic [WCHAR-1:0] chardata_q, rd_data, emit_char;
   logic             emit, load;

   assign encode = 1'b0;

   lz77_search_buf u_sb (
      .clk      (clk),
      .reset    (reset),
      .shift_en (emit),
      .din      (emit_char),
      .rd_idx   (off_q),
      .rd_data  (rd_data)
   );

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      load      = 1'b0;
      emit      = 1'b0;
      emit_char = chardata_q;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load      = 1'b1;
               state_nxt = (match_len != '0) ? COPY : LIT;
            end
         end
         COPY: begin
            // Offset stays fixed, so overlapping copies replay the pattern.
            emit      = 1'b1;
            emit_char = rd_data;
            if (cnt == len_q - 3'd1) state_nxt = LIT;
         end
         LIT: begin
            emit = 1'b1;
            if (chardata_q == END_SGN) begin
               state_nxt = DONE;
            end else begin
               in_ready = 1'b1;
               if (in_valid) begin
                  load      = 1'b1;
                  state_nxt = (match_len != '0) ? COPY : LIT;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         off_q      <= '0;
         len_q      <= '0;
         chardata_q <= '0;
         cnt        <= '0;
         out_valid  <= 1'b0;
         char_nxt   <= '0;
         finish     <= 1'b0;
         err_offset <= 1'b0;
      end else begin
         state     <= state_nxt;
         out_valid <= emit;
         finish    <= (state == DONE);
         if (emit) char_nxt <= emit_char;
         if (load) begin
            off_q      <= offset;
            len_q      <= match_len;
            chardata_q <= chardata;
            cnt        <= '0;
            if (offset >= WOFF'(WSEARCH)) err_offset <= 1'b1;
         end else if (state == COPY) begin
            cnt <= cnt + 3'd1;
         end
      end
   end
endmodule

// File: tb/tb_lz77_decoder_stream.sv
// Directed scoreboard bench for lz77_decoder_stream.
module tb_lz77_decoder_stream;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] offset = '0;
   logic [2:0] match_len = '0;
   logic [7:0] chardata = '0;
   logic       in_ready, out_valid, encode, finish, err_offset;
   logic [7:0] char_nxt;

   lz77_decoder_stream dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .offset     (offset),
      .match_len  (match_len),
      .chardata   (chardata),
      .out_valid  (out_valid),
      .char_nxt   (char_nxt),
      .encode     (encode),
      .finish     (finish),
      .err_offset (err_offset)
   );

   always #5 clk = ~clk;

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         first_c = -1;
   int         last_c = -1;
   int         nem = 0;
   logic [7:0] exp_q[$];
   logic [7:0] msb[9];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: pop one expected char per out_valid cycle.
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) chk("pop_on_empty_queue", 32'(exp_q.size()), 32'd1);
         else chk("char", 32'(char_nxt), 32'(exp_q.pop_front()));
         if (first_c < 0) first_c = cyc;
         last_c = cyc;
         nem++;
      end
   end

   task automatic model_shift(input logic [7:0] c);
      for (int j = 8; j > 0; j--) msb[j] = msb[j-1];
      msb[0] = c;
      exp_q.push_back(c);
   endtask

   task automatic model_token(input logic [3:0] off, input logic [2:0] len, input logic [7:0] ch);
      logic [7:0] c;
      for (int i = 0; i < int'(len); i++) begin
         c = (off < 4'd9) ? msb[off] : 8'h00;
         model_shift(c);
      end
      model_shift(ch);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      for (int j = 0; j < 9; j++) msb[j] = 8'h00;
   endtask

   task automatic send(input logic [3:0] off, input logic [2:0] len, input logic [7:0] ch);
      int n;
      n = 0;
      offset = off;
      match_len = len;
      chardata = ch;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("accept", 32'(in_ready), 32'd1);
      model_token(off, len, ch);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic win_clr();
      first_c = -1;
      last_c = -1;
      nem = 0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_char_nxt", 32'(char_nxt), 32'd0);
      chk("rst_finish", 32'(finish), 32'd0);
      chk("rst_err", 32'(err_offset), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("encode", 32'(encode), 32'd0);

      // literals a,b,$ then finish
      win_clr();
      send(4'd0, 3'd0, 8'h61);
      send(4'd0, 3'd0, 8'h62);
      send(4'd0, 3'd0, 8'h24);
      chk("rdy_end_lit", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      drain();
      chk("lit_count", 32'(nem), 32'd3);
      chk("lit_span", 32'(last_c - first_c + 1), 32'd3);
      chk("finish_set", 32'(finish), 32'd1);
      chk("done_rdy", 32'(in_ready), 32'd0);
      offset = 4'd0; match_len = 3'd0; chardata = 8'h41; in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("done_no_out", 32'(out_valid), 32'd0);
      chk("finish_hold", 32'(finish), 32'd1);
      in_valid = 1'b0;

      // simple copy after "abc"
      do_reset();
      send(4'd0, 3'd0, 8'h61);
      send(4'd0, 3'd0, 8'h62);
      send(4'd0, 3'd0, 8'h63);
      send(4'd2, 3'd3, 8'h64);
      send(4'd3, 3'd1, 8'h65);
      in_valid = 1'b0;
      drain();

      // overlapping copy
      do_reset();
      send(4'd0, 3'd0, 8'h61);
      in_valid = 1'b0;
      drain();
      win_clr();
      send(4'd0, 3'd7, 8'h78);
      chk("rdy_copy_ovl", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      drain();
      chk("ovl_count", 32'(nem), 32'd8);
      chk("ovl_span", 32'(last_c - first_c + 1), 32'd8);

      // back-to-back tokens
      win_clr();
      send(4'd0, 3'd0, 8'h70);
      send(4'd1, 3'd2, 8'h72);
      chk("rdy_copy_b2b", 32'(in_ready), 32'd0);
      send(4'd0, 3'd0, 8'h73);
      send(4'd2, 3'd1, 8'h74);
      in_valid = 1'b0;
      drain();
      chk("b2b_count", 32'(nem), 32'd7);
      chk("b2b_span", 32'(last_c - first_c + 1), 32'd7);

      // window edge
      do_reset();
      for (int i = 0; i < 9; i++) send(4'd0, 3'd0, 8'(8'h30 + i));
      send(4'd8, 3'd2, 8'h24);
      in_valid = 1'b0;
      drain();
      chk("edge_finish", 32'(finish), 32'd1);

      // offset out of window
      do_reset();
      chk("err_clear", 32'(err_offset), 32'd0);
      send(4'd9, 3'd1, 8'h7a);
      in_valid = 1'b0;
      drain();
      chk("err_set", 32'(err_offset), 32'd1);

      // reset mid-copy
      do_reset();
      send(4'd0, 3'd0, 8'h6d);
      send(4'd0, 3'd7, 8'h71);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_char", 32'(char_nxt), 32'd0);
      chk("midrst_rdy", 32'(in_ready), 32'd1);
      chk("midrst_popped", 32'(exp_q.size()), 32'd5);
      do_reset();
      send(4'd0, 3'd1, 8'h6b);
      in_valid = 1'b0;
      drain();
      chk("post_rst_finish", 32'(finish), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
